// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE, GRANT)
//   idw_f       : width of a requester index for a given requester count
//   bcw_f       : width of a burst counter able to hold 0..max_burst
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  function automatic int idw_f(input int nreq);
    return (nreq < 2) ? 1 : $clog2(nreq);
  endfunction

  function automatic int bcw_f(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req[] upward (modulo NREQ) starting at last+1 and returns the
// first set index.
//   req   : in  NREQ  request vector
//   last  : in  IDW   most recently served index
//   found : out 1     at least one request bit is set
//   idx   : out IDW   chosen index (equals last when nothing is found)
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = idw_f(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  // cand[k] is the index examined at search distance k+1 from last.
  logic [IDW-1:0]  cand [NREQ];
  logic [NREQ-1:0] hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign cand[gi] = IDW'((int'(last) + 1 + gi) % NREQ);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Walk from the far end back so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = last;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// A winner holds the port for up to MAX_BURST accepted words; every word
// written is tagged with the source index in its upper bits.
//   clk          : in  1                clock
//   nrst         : in  1                synchronous active-low reset
//   req_valid    : in  NREQ             per-requester valid
//   req_data     : in  NREQ*DATA_WIDTH  payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready    : out NREQ             per-requester ready, one-hot or zero
//   fifo_full    : in  1                FIFO full flag
//   fifo_w_en    : out 1                FIFO write enable
//   fifo_data_in : out IDW+DATA_WIDTH   {grant_id, payload}
//   grant_id     : out IDW              current (or last) granted requester
//   busy         : out 1                high while a grant is active
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDW = idw_f(NREQ),
  localparam int BCW = bcw_f(MAX_BURST)
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_w_en,
  output logic [IDW+DATA_WIDTH-1:0]  fifo_data_in,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy
);

  arb_state_t     state_reg, state_next;
  logic [IDW-1:0] grant_reg, grant_next;
  logic [IDW-1:0] last_reg, last_next;
  logic [BCW-1:0] burst_reg, burst_next;

  logic                  pick_found;
  logic [IDW-1:0]        pick_idx;
  logic                  granted_valid;
  logic [DATA_WIDTH-1:0] granted_data;
  logic                  ready_bit;
  logic                  accept;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (req_valid),
    .last  (last_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign granted_valid = req_valid[grant_reg];
  assign granted_data  = req_data[grant_reg*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      last_reg  <= IDW'(NREQ - 1);   // requester 0 searched first after reset
      burst_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      burst_reg <= burst_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    burst_next = burst_reg;
    req_ready  = '0;
    ready_bit  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = pick_idx;
          burst_next = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        // Ready is held low during reset so a handshake in the reset cycle
        // never turns into a FIFO write.
        ready_bit            = !fifo_full && nrst;
        req_ready[grant_reg] = ready_bit;
        accept               = granted_valid && ready_bit;
        if (accept) begin
          burst_next = burst_reg + 1'b1;
        end
        // A full FIFO stalls the burst but keeps the grant; only a dropped
        // valid or the final beat of the burst releases it.
        if (!granted_valid || (accept && burst_reg == BCW'(MAX_BURST - 1))) begin
          state_next = IDLE;
          last_next  = grant_reg;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign fifo_w_en    = accept;
  assign fifo_data_in = {grant_reg, granted_data};
  assign grant_id     = grant_reg;
  assign busy         = (state_reg == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic          clk;
  logic          nrst;
  logic [3:0]    req_valid;
  logic [31:0]   req_data;
  logic [3:0]    req_ready;
  logic          fifo_full;
  logic          fifo_w_en;
  logic [9:0]    fifo_data_in;
  logic [1:0]    grant_id;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter #(
    .NREQ       (NREQ),
    .DATA_WIDTH (DW),
    .MAX_BURST  (4)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        nrst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic        full;
    logic [3:0]  ready;
    logic        wen;
    logic [9:0]  din;
    logic [1:0]  gid;
    logic        busy;
    logic        chk;
  } vec_t;

  localparam logic [31:0] D0 = 32'h44332211;
  localparam logic [31:0] D5 = 32'hA5332211;

  vec_t vecs[$];

  task automatic add(input logic n, input logic [3:0] v, input logic [31:0] d, input logic f,
                     input logic [3:0] r, input logic w, input logic [9:0] di,
                     input logic [1:0] g, input logic b, input logic c);
    vec_t t;
    t.nrst = n; t.valid = v; t.data = d; t.full = f;
    t.ready = r; t.wen = w; t.din = di; t.gid = g; t.busy = b; t.chk = c;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] r, input logic w,
                               input logic [9:0] di, input logic [1:0] g, input logic b);
    check({tag, " req_ready"}, 32'(req_ready), 32'(r));
    check({tag, " fifo_w_en"}, 32'(fifo_w_en), 32'(w));
    check({tag, " fifo_data_in"}, 32'(fifo_data_in), 32'(di));
    check({tag, " grant_id"}, 32'(grant_id), 32'(g));
    check({tag, " busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    logic [1:0] eg;
    logic [7:0] pay;
    nrst = 1'b0; req_valid = '0; req_data = D0; fifo_full = 1'b0;

    // reset
    add(0, 4'b0000, D0, 0, 4'b0000, 0, 10'h011, 0, 0, 0);
    add(0, 4'b0000, D0, 0, 4'b0000, 0, 10'h011, 0, 0, 1);
    // single requester 2: grant next cycle, four writes, release
    add(1, 4'b0100, D0, 0, 4'b0000, 0, 10'h011, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 4'b0100, D0, 0, 4'b0100, 1, 10'h233, 2, 1, 1);
    add(1, 4'b0100, D0, 0, 4'b0000, 0, 10'h233, 2, 0, 1);
    add(1, 4'b0000, D0, 0, 4'b0100, 0, 10'h233, 2, 1, 1);   // re-granted alone, valid dropped
    // requester 1 alone for 2 beats, then valid drop releases
    add(1, 4'b0010, D0, 0, 4'b0000, 0, 10'h233, 2, 0, 1);
    for (int i = 0; i < 2; i++) add(1, 4'b0010, D0, 0, 4'b0010, 1, 10'h122, 1, 1, 1);
    add(1, 4'b0000, D0, 0, 4'b0010, 0, 10'h122, 1, 1, 1);
    // last_grant=1, so with 0 and 1 valid the search from 2 wraps to 0
    add(1, 4'b0011, D0, 0, 4'b0000, 0, 10'h122, 1, 0, 1);
    for (int i = 0; i < 2; i++) add(1, 4'b0011, D0, 0, 4'b0001, 1, 10'h011, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 4'b0011, D0, 1, 4'b0000, 0, 10'h011, 0, 1, 1);
    for (int i = 0; i < 2; i++) add(1, 4'b0011, D0, 0, 4'b0001, 1, 10'h011, 0, 1, 1);
    add(1, 4'b0011, D0, 0, 4'b0000, 0, 10'h011, 0, 0, 1);
    add(1, 4'b0000, D0, 0, 4'b0010, 0, 10'h122, 1, 1, 1);
    // requester 3 with payload A5
    add(1, 4'b1000, D5, 0, 4'b0000, 0, 10'h122, 1, 0, 1);
    add(1, 4'b1000, D5, 0, 4'b1000, 1, 10'h3A5, 3, 1, 1);
    add(1, 4'b0000, D5, 0, 4'b1000, 0, 10'h3A5, 3, 1, 1);
    // reset during third beat of requester 2
    add(1, 4'b0100, D0, 0, 4'b0000, 0, 10'h344, 3, 0, 1);
    for (int i = 0; i < 2; i++) add(1, 4'b0100, D0, 0, 4'b0100, 1, 10'h233, 2, 1, 1);
    add(0, 4'b1111, D0, 0, 4'b0000, 0, 10'h233, 2, 1, 1);
    add(1, 4'b1111, D0, 0, 4'b0000, 0, 10'h011, 0, 0, 1);
    add(1, 4'b1111, D0, 0, 4'b0001, 1, 10'h011, 0, 1, 1);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      nrst = vecs[i].nrst; req_valid = vecs[i].valid;
      req_data = vecs[i].data; fifo_full = vecs[i].full;
      @(negedge clk);
      $display("vec %0d: nrst=%0b valid=%b full=%0b -> ready=%b w_en=%0b data_in=%h gid=%0d busy=%0b",
               i, nrst, req_valid, fifo_full, req_ready, fifo_w_en, fifo_data_in, grant_id, busy);
      if (vecs[i].chk)
        check_outputs($sformatf("vec%0d", i), vecs[i].ready, vecs[i].wen,
                      vecs[i].din, vecs[i].gid, vecs[i].busy);
    end

    // Saturated round robin: all valid after reset -> grants 0,1,2,3,0,
    // four writes each with one IDLE bubble between grants.
    @(posedge clk); #1;
    nrst = 1'b0; req_valid = 4'b1111; req_data = D0; fifo_full = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (c % 5 == 0) begin
        eg  = (c == 0) ? 2'd0 : 2'((c / 5 - 1) % 4);
        pay = D0[8*eg +: 8];
        $display("rr cycle %0d: bubble gid=%0d w_en=%0b busy=%0b", c, grant_id, fifo_w_en, busy);
        check_outputs($sformatf("rr%0d", c), 4'b0000, 1'b0, {eg, pay}, eg, 1'b0);
      end else begin
        eg  = 2'((c / 5) % 4);
        pay = D0[8*eg +: 8];
        $display("rr cycle %0d: write data_in=%h gid=%0d", c, fifo_data_in, grant_id);
        check_outputs($sformatf("rr%0d", c), 4'b0001 << eg, 1'b1, {eg, pay}, eg, 1'b1);
      end
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
